// File: rtl/l2_mem_port.sv
`default_nettype none
// ============================================================================
// l2_mem_port: L2 miss port. Optional victim writeback, then block fill, with a per-request timeout.
// Rev 1.0
// ============================================================================
module l2_mem_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             req_wb,
  input  logic [ADDR_WIDTH-1:0]            req_wb_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req_wb_data,
  output logic                             resp_valid,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] resp_data,
  output logic                             resp_err,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  input  logic                             mem_ready
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WB   = 2'd1;
  localparam logic [1:0] c_FILL = 2'd2;
  localparam logic [1:0] c_RESP = 2'd3;

  localparam logic [15:0]           c_LAST       = 16'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(BLOCK_SIZE - 1);

  logic [1:0]            r_state;
  logic [15:0]           r_cnt;
  logic                  r_gap;
  logic [ADDR_WIDTH-1:0] r_fill_addr;
  logic                  w_honour;
  logic                  w_expire;

  // A zero count marks the first strobe cycle, where mem_ready may still be stale.
  assign w_honour = mem_ready && (r_cnt != 16'd0) && !r_gap;
  assign w_expire = (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_cnt       <= 16'd0;
      r_gap       <= 1'b0;
      r_fill_addr <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_data   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            r_cnt       <= 16'd0;
            r_fill_addr <= req_addr & c_ALIGN_MASK;
            if (req_wb) begin
              r_state   <= c_WB;
              mem_write <= 1'b1;
              mem_addr  <= req_wb_addr & c_ALIGN_MASK;
              mem_wdata <= req_wb_data;
            end else begin
              r_state   <= c_FILL;
              mem_read  <= 1'b1;
              mem_addr  <= req_addr & c_ALIGN_MASK;
            end
          end
        end
        c_WB: begin
          if (w_honour) begin
            mem_write <= 1'b0;
            r_state   <= c_FILL;
            r_gap     <= 1'b1;
            r_cnt     <= 16'd0;
          end else if (w_expire) begin
            mem_write  <= 1'b0;
            r_state    <= c_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_FILL: begin
          // The gap cycle separates the write and read strobes; the wait count starts after it.
          if (r_gap) begin
            r_gap    <= 1'b0;
            mem_read <= 1'b1;
            mem_addr <= r_fill_addr;
          end else if (w_honour) begin
            mem_read   <= 1'b0;
            resp_data  <= mem_rdata;
            r_state    <= c_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
          end else if (w_expire) begin
            mem_read   <= 1'b0;
            r_state    <= c_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state   <= c_IDLE;
          req_ready <= 1'b1;
          resp_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_port.sv
`default_nettype none
// Testbench for l2_mem_port: randomized miss traffic against a phase-level model of the memory handshake.
module tb_l2_mem_port;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 16;
  localparam int TO = 8;
  localparam int BW = DW * BS;

  typedef logic [BW-1:0] blk_t;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_wb;
  logic [AW-1:0] req_wb_addr;
  blk_t          req_wb_data;
  logic          resp_valid;
  blk_t          resp_data;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  blk_t          mem_wdata;
  blk_t          mem_rdata;
  logic          mem_read;
  logic          mem_write;
  logic          mem_ready;

  int   n_chk  = 0;
  int   n_pass = 0;
  blk_t exp_data;

  l2_mem_port #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BLOCK_SIZE(BS),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wb     (req_wb),
    .req_wb_addr(req_wb_addr),
    .req_wb_data(req_wb_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input blk_t got, input blk_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return (a / BS) * BS;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = $urandom();
    return b;
  endfunction

  // One strobe phase. r<0: ready stuck high; r==0: never; r>0: ready from the r-th strobe cycle.
  // Ready is honoured at the earliest strobe cycle >= 2 where it is high, and only up to cycle TO.
  task automatic phase(input bit is_wr, input logic [AW-1:0] a, input blk_t wd,
                       input int r, output bit timed_out);
    int  hon;
    int  len;
    bit  stale;
    stale     = (r < 0);
    hon       = stale ? 2 : ((r == 0) ? TO + 1 : ((r < 2) ? 2 : r));
    timed_out = (hon > TO);
    len       = timed_out ? TO : hon;
    for (int j = 1; j <= len; j++) begin
      mem_ready = stale || (r > 0 && j >= r);
      check(is_wr ? "wr_strobe" : "rd_strobe", blk_t'({mem_write, mem_read}),
            is_wr ? blk_t'(2'b10) : blk_t'(2'b01));
      check(is_wr ? "wr_addr" : "rd_addr", blk_t'(mem_addr), blk_t'(a));
      if (is_wr) check("wr_data", mem_wdata, wd);
      check("busy_flags", blk_t'({req_ready, resp_valid}), '0);
      step();
    end
    mem_ready = stale;
  endtask

  task automatic idle(input int n, input bit rdy);
    mem_ready = rdy;
    for (int i = 0; i < n; i++) begin
      check("idle_flags", blk_t'({req_ready, resp_valid, mem_read, mem_write}), blk_t'(4'b1000));
      step();
    end
  endtask

  task automatic run_txn(input bit wb, input logic [AW-1:0] wa, input logic [AW-1:0] fa,
                         input blk_t wd, input blk_t rd, input int rw, input int rr);
    bit to;
    to = 1'b0;
    check("accept_ready", blk_t'(req_ready), blk_t'(1'b1));
    req_valid   = 1'b1;
    req_wb      = wb;
    req_wb_addr = wa;
    req_addr    = fa;
    req_wb_data = wd;
    mem_rdata   = rd;
    mem_ready   = ((wb ? rw : rr) < 0);
    step();
    req_valid   = 1'b0;
    req_wb      = 1'($urandom());
    req_addr    = $urandom();
    req_wb_addr = $urandom();
    req_wb_data = rand_blk();
    if (wb) begin
      phase(1'b1, align(wa), wd, rw, to);
      if (!to) begin
        mem_ready = (rw < 0) || (rr < 0) || 1'($urandom_range(0, 1));
        check("gap_cycle", blk_t'({mem_write, mem_read, req_ready, resp_valid}), '0);
        step();
      end
    end
    if (!to) phase(1'b0, align(fa), '0, rr, to);
    if (!to) exp_data = rd;
    check("resp_valid", blk_t'(resp_valid), blk_t'(1'b1));
    check("resp_err", blk_t'(resp_err), blk_t'(to));
    check("resp_strobes", blk_t'({mem_write, mem_read, req_ready}), '0);
    check("resp_data", resp_data, exp_data);
    step();
    mem_rdata = rand_blk();
    mem_ready = 1'b0;
    check("post_resp", blk_t'({req_ready, resp_valid}), blk_t'(2'b10));
    check("data_hold", resp_data, exp_data);
  endtask

  initial begin
    blk_t rd;
    blk_t wd;
    int   rw;
    int   rr;

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_wb      = 1'b0;
    req_addr    = '0;
    req_wb_addr = '0;
    req_wb_data = '0;
    mem_rdata   = '0;
    mem_ready   = 1'b0;
    exp_data    = '0;
    repeat (3) step();

    check("rst_flags", blk_t'({req_ready, resp_valid, resp_err, mem_read, mem_write}),
          blk_t'(5'b10000));
    check("rst_mem_addr", blk_t'(mem_addr), '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_resp_data", resp_data, '0);
    rst_n = 1'b1;
    idle(2, 1'b0);

    // Fill only, minimum latency.
    for (int i = 0; i < BS; i++) rd[i*DW +: DW] = 32'hA0 + i;
    run_txn(1'b0, '0, 32'h13, '0, rd, 0, 2);
    idle(1, 1'b0);

    // Writeback then fill.
    run_txn(1'b1, 32'h47, 32'h80, rand_blk(), rand_blk(), 2, 2);
    idle(1, 1'b0);

    // Stale ready held high throughout, including idle.
    idle(3, 1'b1);
    run_txn(1'b1, 32'h1234, 32'h5678, rand_blk(), rand_blk(), -1, -1);
    idle(2, 1'b1);

    // Fill timeout, then ready exactly on the last counted cycle, then one cycle too late.
    run_txn(1'b0, '0, 32'h300, '0, rand_blk(), 0, 0);
    run_txn(1'b0, '0, 32'h310, '0, rand_blk(), 0, TO);
    run_txn(1'b0, '0, 32'h320, '0, rand_blk(), 0, TO + 1);

    // Writeback timeout skips the fill.
    run_txn(1'b1, 32'h77, 32'h90, rand_blk(), rand_blk(), 0, 2);
    idle(1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rw = int'($urandom_range(0, 12)) - 1;
      rr = int'($urandom_range(0, 12)) - 1;
      wd = rand_blk();
      rd = rand_blk();
      run_txn(1'($urandom()), $urandom(), $urandom(), wd, rd, rw, rr);
      idle(int'($urandom_range(0, 2)), 1'($urandom()));
    end

    // Reset in the middle of a fill.
    req_valid = 1'b1;
    req_wb    = 1'b0;
    req_addr  = 32'hABC0;
    mem_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    check("mid_fill_read", blk_t'(mem_read), blk_t'(1'b1));
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    exp_data = '0;
    check("abort_flags", blk_t'({req_ready, resp_valid, mem_read, mem_write}), blk_t'(4'b1000));
    check("abort_data", resp_data, exp_data);
    idle(TO + 4, 1'b1);
    run_txn(1'b0, '0, 32'h40, '0, rand_blk(), 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/l2_mem_port.md
L2_MEM_PORT -- requirements
Module: l2_mem_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per memory word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, word-address width.
REQ-003 SHALL have parameter BLOCK_SIZE, default 16, words per block (power of two).
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per memory request (1..65535).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  1  L2 miss request present.
REQ-008 req_ready  output  1  block accepts a request.
REQ-009 req_addr  input  ADDR_WIDTH  fill (miss) address.
REQ-010 req_wb  input  1  dirty victim to write back before the fill.
REQ-011 req_wb_addr  input  ADDR_WIDTH  victim address.
REQ-012 req_wb_data  input  BLOCK_SIZE*DATA_WIDTH  victim block; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_data  output  BLOCK_SIZE*DATA_WIDTH  fill block, same packing.
REQ-015 resp_err  output  1  completion was a timeout; qualified by resp_valid.
REQ-016 mem_addr  output  ADDR_WIDTH  block-aligned memory address.
REQ-017 mem_wdata  output  BLOCK_SIZE*DATA_WIDTH  block to memory.
REQ-018 mem_rdata  input  BLOCK_SIZE*DATA_WIDTH  block from memory.
REQ-019 mem_read / mem_write  output  1 each  memory request strobes, never both high.
REQ-020 mem_ready  input  1  memory completion, registered by memory.

Function
REQ-021 States SHALL be IDLE, WB, FILL, RESP; all outputs registered.
REQ-022 req_ready SHALL be 1 only in IDLE; acceptance is req_valid&&req_ready at a rising edge; request fields captured at that edge.
REQ-023 Accept with req_wb=1 SHALL enter WB; otherwise FILL.
REQ-024 Addresses SHALL be aligned: low log2(BLOCK_SIZE) bits of mem_addr forced to 0.
REQ-025 WB SHALL hold mem_write=1, mem_addr=aligned victim address, mem_wdata=victim block until exit.
REQ-026 FILL SHALL hold mem_read=1, mem_addr=aligned fill address until exit.
REQ-027 mem_ready SHALL be ignored in the first cycle of WB or FILL and in IDLE/RESP (stale ready from a previous request).
REQ-028 WB with honoured mem_ready SHALL go to FILL; strobes low for exactly one cycle between WB and FILL.
REQ-029 FILL with honoured mem_ready SHALL capture mem_rdata into resp_data and go to RESP.
REQ-030 A 16-bit wait counter SHALL clear on entry to WB/FILL and increment each cycle there; when it reaches TIMEOUT without honoured mem_ready, go to RESP with resp_err=1 (fill skipped after WB timeout).
REQ-031 Honoured mem_ready in the same cycle the counter reaches TIMEOUT SHALL win (success).
REQ-032 RESP SHALL pulse resp_valid=1 for one cycle, then IDLE; resp_data holds its value until next capture.
REQ-033 Minimum latency, no writeback: accept at edge t0, mem_read high in cycle t1, mem_ready in t2, resp_valid in t3.
REQ-034 Strobes SHALL drop the cycle after the honoured mem_ready.

Reset
REQ-035 rst_n=0 at a rising edge SHALL force IDLE, req_ready=1 after reset, resp_valid=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, resp_data=0, counter=0, aborting any in-flight request without response.

Verification
REQ-036 Fill only: req_addr=0x0000_0013, req_wb=0, mem_ready one cycle after read seen, mem_rdata words 0..15 = 0xA0..0xAF -> mem_addr=0x10, resp_valid at t3, resp_data matches, resp_err=0.
REQ-037 Writeback+fill: req_wb=1, req_wb_addr=0x47, req_addr=0x80 -> mem_write with mem_addr=0x40 and victim data, one idle cycle, mem_read with mem_addr=0x80, then response.
REQ-038 Stale ready: mem_ready held high continuously -> first cycle of each state ignored; exactly one write then one read issued.
REQ-039 Timeout: TIMEOUT=8, mem_ready never asserted -> resp_valid with resp_err=1 after 8 FILL cycles; req_ready back next cycle.
REQ-040 Boundary: mem_ready in the cycle counter reaches TIMEOUT -> resp_err=0, data captured.
REQ-041 Reset mid-FILL -> next cycle mem_read=0, req_ready=1, no resp_valid.
